// File: rtl/start_arbiter_if.sv
// start_arbiter_if: request/release handshake and one-hot grant bus between requesters and the arbiter.
interface start_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] done_i;
  logic [N_REQ-1:0] gnt_o;
  modport master(output req_i, done_i, input gnt_o);
  modport slave(input req_i, done_i, output gnt_o);
endinterface

// File: rtl/start_arbiter.sv
// start_arbiter: IDLE->INIT->STRT bring-up, then round-robin one-hot grants with a per-grant hold watchdog.
module start_arbiter #(
  parameter int N_REQ       = 4,
  parameter int INIT_CYCLES = 8,
  parameter int MAX_HOLD    = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  stop_i,
  start_arbiter_if.slave        bus,
  output logic [2:0]            state_o,
  output logic                  ready_o,
  output logic                  timeout_o
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int HW = $clog2(MAX_HOLD);
  typedef logic [PW:0] ext_t;
  typedef enum logic [2:0] {IDLE = 3'b001, INIT = 3'b010, STRT = 3'b100} state_t;

  state_t           state, state_n;
  logic [IW-1:0]    init_cnt, init_n;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic [PW-1:0]    ptr, ptr_n, gidx, gidx_n, sel, nxt;
  logic [N_REQ-1:0] gnt, gnt_n;
  logic             to_r, to_n, found, rel;

  assign state_o   = state;
  assign ready_o   = (state == STRT);
  assign timeout_o = to_r;
  assign bus.gnt_o = gnt;

  // Descending scan so the requester closest to the pointer wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      ext_t s;
      s = {1'b0, ptr} + ext_t'(i);
      s = (s >= ext_t'(N_REQ)) ? s - ext_t'(N_REQ) : s;
      if (bus.req_i[s[PW-1:0]]) begin
        found = 1'b1;
        sel   = s[PW-1:0];
      end
    end
  end

  assign rel = bus.done_i[gidx] | ~bus.req_i[gidx];
  assign nxt = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

  always_comb begin
    state_n = state;
    init_n  = init_cnt;
    hold_n  = hold_cnt;
    ptr_n   = ptr;
    gidx_n  = gidx;
    gnt_n   = gnt;
    to_n    = 1'b0;
    case (state)
      IDLE: begin
        gnt_n = '0;
        if (enable_i && !stop_i) begin
          state_n = INIT;
          init_n  = IW'(INIT_CYCLES - 1);
        end
      end
      INIT: begin
        gnt_n = '0;
        if (stop_i || !enable_i) state_n = IDLE;
        else if (init_cnt == '0) state_n = STRT;
        else init_n = init_cnt - 1'b1;
      end
      STRT: begin
        if (stop_i || !enable_i) begin
          state_n = IDLE;
          gnt_n   = '0;
        end else if (gnt == '0) begin
          if (found) begin
            gnt_n  = N_REQ'(1) << sel;
            gidx_n = sel;
            hold_n = '0;
          end
        end else if (rel) begin
          gnt_n = '0;
          ptr_n = nxt;
        end else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
          gnt_n = '0;
          to_n  = 1'b1;
          ptr_n = nxt;
        end else hold_n = hold_cnt + 1'b1;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= IDLE;
      init_cnt <= '0;
      hold_cnt <= '0;
      ptr      <= '0;
      gidx     <= '0;
      gnt      <= '0;
      to_r     <= 1'b0;
    end else begin
      state    <= state_n;
      init_cnt <= init_n;
      hold_cnt <= hold_n;
      ptr      <= ptr_n;
      gidx     <= gidx_n;
      gnt      <= gnt_n;
      to_r     <= to_n;
    end
  end
endmodule

// File: tb/tb_start_arbiter.sv
// tb_start_arbiter: directed bring-up, round-robin, watchdog, shutdown and reset checks for start_arbiter.
module tb_start_arbiter;
  logic       clock_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       enable_i = 1'b0;
  logic       stop_i = 1'b0;
  logic [2:0] state_o;
  logic       ready_o, timeout_o;
  int         n_cmp = 0;
  int         n_err = 0;

  start_arbiter_if #(.N_REQ(4)) bus ();

  start_arbiter #(.N_REQ(4), .INIT_CYCLES(8), .MAX_HOLD(16)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .stop_i(stop_i),
    .bus(bus), .state_o(state_o), .ready_o(ready_o), .timeout_o(timeout_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick;
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [2:0] st, input logic rdy, input logic to);
    chk({tag, ".gnt"}, {4'b0, bus.gnt_o}, {4'b0, g});
    chk({tag, ".state"}, {5'b0, state_o}, {5'b0, st});
    chk({tag, ".ready"}, {7'b0, ready_o}, {7'b0, rdy});
    chk({tag, ".timeout"}, {7'b0, timeout_o}, {7'b0, to});
  endtask

  initial begin
    logic [3:0] rr [5];
    rr[0] = 4'b0001; rr[1] = 4'b0010; rr[2] = 4'b0100; rr[3] = 4'b1000; rr[4] = 4'b0001;
    bus.req_i  = '0;
    bus.done_i = '0;
    tick; tick; tick;
    chk_all("reset", 4'b0, 3'b001, 1'b0, 1'b0);
    reset_i  = 1'b1;
    enable_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick;
      chk_all("bringup_init", 4'b0, 3'b010, 1'b0, 1'b0);
    end
    tick;
    chk_all("bringup_strt", 4'b0, 3'b100, 1'b1, 1'b0);
    bus.req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk_all("rr_cyc1", rr[k], 3'b100, 1'b1, 1'b0);
      tick;
      chk_all("rr_cyc2", rr[k], 3'b100, 1'b1, 1'b0);
      bus.done_i = rr[k];
      tick;
      chk_all("rr_gap", 4'b0, 3'b100, 1'b1, 1'b0);
      bus.done_i = '0;
    end
    bus.req_i = 4'b0100;
    tick;
    chk_all("wd_grant", 4'b0100, 3'b100, 1'b1, 1'b0);
    bus.done_i = 4'b1011;
    for (int k = 2; k <= 16; k++) begin
      tick;
      chk_all("wd_hold", 4'b0100, 3'b100, 1'b1, 1'b0);
    end
    tick;
    chk_all("wd_revoke", 4'b0, 3'b100, 1'b1, 1'b1);
    tick;
    chk_all("wd_regrant", 4'b0100, 3'b100, 1'b1, 1'b0);
    bus.done_i = '0;
    for (int k = 2; k <= 15; k++) tick;
    chk_all("col_cyc15", 4'b0100, 3'b100, 1'b1, 1'b0);
    tick;
    chk_all("col_cyc16", 4'b0100, 3'b100, 1'b1, 1'b0);
    bus.done_i = 4'b0100;
    tick;
    chk_all("col_release", 4'b0, 3'b100, 1'b1, 1'b0);
    bus.done_i = '0;
    bus.req_i  = 4'b1111;
    tick;
    chk_all("col_ptr3", 4'b1000, 3'b100, 1'b1, 1'b0);
    bus.done_i = 4'b1000;
    tick;
    bus.done_i = '0;
    tick;
    chk_all("sd_g0", 4'b0001, 3'b100, 1'b1, 1'b0);
    bus.done_i = 4'b0001;
    tick;
    bus.done_i = '0;
    tick;
    chk_all("sd_g1", 4'b0010, 3'b100, 1'b1, 1'b0);
    stop_i = 1'b1;
    tick;
    chk_all("sd_stop", 4'b0, 3'b001, 1'b0, 1'b0);
    tick;
    chk_all("sd_stop_wins", 4'b0, 3'b001, 1'b0, 1'b0);
    stop_i = 1'b0;
    tick;
    chk_all("sd_init1", 4'b0, 3'b010, 1'b0, 1'b0);
    tick;
    tick;
    chk_all("sd_init3", 4'b0, 3'b010, 1'b0, 1'b0);
    enable_i = 1'b0;
    tick;
    chk_all("sd_enable_low", 4'b0, 3'b001, 1'b0, 1'b0);
    enable_i  = 1'b1;
    bus.req_i = 4'b1000;
    for (int k = 0; k < 9; k++) tick;
    chk_all("mr_strt", 4'b0, 3'b100, 1'b1, 1'b0);
    tick;
    chk_all("mr_grant", 4'b1000, 3'b100, 1'b1, 1'b0);
    #2 reset_i = 1'b0;
    #1 chk_all("mr_async", 4'b0, 3'b001, 1'b0, 1'b0);
    #1 reset_i = 1'b1;
    bus.req_i = 4'b1111;
    for (int k = 0; k < 9; k++) tick;
    chk_all("mr_restrt", 4'b0, 3'b100, 1'b1, 1'b0);
    tick;
    chk_all("mr_ptr0", 4'b0001, 3'b100, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
